// File: rtl/cpu_pkg.sv
// Shared hazard-control types for the five-stage RV32 core: forwarding
// selects, hazard FSM states and the destination-register shadow entry.
package cpu_pkg;

  localparam int CPU_REG_AW   = 5;
  localparam int CPU_BR_FLUSH = 3;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_EXE_MEM = 2'b01,
    FWD_MEM_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_LU_STALL = 2'b01,
    HZ_MEM_WAIT = 2'b10
  } hz_state_t;

  // Destination-register state of one pipeline stage.
  typedef struct packed {
    logic                  valid;
    logic [CPU_REG_AW-1:0] rd;
    logic                  we;
    logic                  is_load;
    logic                  is_mem;
  } shadow_t;

  // Entry used for bubbles, flushed slots and reset.
  function automatic shadow_t shadow_bubble();
    shadow_t e;
    e = '0;
    return e;
  endfunction

  // True when the entry will write register rs (x0 never counts).
  function automatic logic is_producer(shadow_t e, logic [CPU_REG_AW-1:0] rs);
    return e.valid && e.we && (e.rd != {CPU_REG_AW{1'b0}}) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Single-operand forwarding compare: picks the newest in-flight producer
// of the source register, EXE (becoming MEM) ahead of MEM (becoming WB).
module fwd_unit
  import cpu_pkg::*;
(
  input  logic                  i_valid,
  input  logic                  i_used,
  input  logic [CPU_REG_AW-1:0] i_rs,
  input  shadow_t               i_exe,
  input  shadow_t               i_mem,
  output fwd_sel_t              o_sel
);

  // Priority compare; invalid or unused sources read the register file.
  always_comb begin
    o_sel = FWD_RF;
    if (i_valid && i_used) begin
      if (is_producer(i_exe, i_rs)) begin
        o_sel = FWD_EXE_MEM;
      end else if (is_producer(i_mem, i_rs)) begin
        o_sel = FWD_MEM_WB;
      end else begin
        o_sel = FWD_RF;
      end
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow pipe of EXE/MEM/WB destinations,
// forwarding selects, load-use stall, taken-branch flush and memory freeze.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW   = CPU_REG_AW,
  parameter int BR_FLUSH = CPU_BR_FLUSH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_rd_we,
  input  logic                id_is_load,
  input  logic                id_is_store,
  input  logic                mem_br_taken,
  input  logic                mem_ready,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_exe,
  output logic                freeze,
  output logic [BR_FLUSH-1:0] flush,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  shadow_t   r_exe;
  shadow_t   r_mem;
  shadow_t   r_wb;
  shadow_t   w_id_entry;
  hz_state_t r_state;
  hz_state_t w_state_nxt;
  fwd_sel_t  r_fwd_a;
  fwd_sel_t  r_fwd_b;
  fwd_sel_t  w_fwd_a;
  fwd_sel_t  w_fwd_b;
  logic      w_mem_wait;
  logic      w_branch;
  logic      w_lu_hit;
  logic      w_lu_stall;
  logic      w_wb_unused;

  // WB entry is kept for debug visibility only; nothing downstream reads it.
  assign w_wb_unused = ^r_wb;

  // The memory stage is busy: everything holds until the access completes.
  assign w_mem_wait = r_mem.valid && r_mem.is_mem && !mem_ready;
  // A taken branch is only acted on when the pipe is not frozen.
  assign w_branch   = mem_br_taken && !w_mem_wait;
  assign w_lu_hit   = id_valid && r_exe.valid && r_exe.is_load &&
                      (r_exe.rd != {CPU_REG_AW{1'b0}}) &&
                      ((id_rs1_used && (id_rs1 == r_exe.rd)) ||
                       (id_rs2_used && (id_rs2 == r_exe.rd)));
  // A squashed ID instruction never stalls; one bubble is enough per load.
  assign w_lu_stall = w_lu_hit && !w_branch && !w_mem_wait &&
                      (r_state != HZ_LU_STALL);

  // Pack the ID instruction into a shadow entry.
  always_comb begin
    w_id_entry         = shadow_bubble();
    w_id_entry.valid   = id_valid;
    w_id_entry.rd      = id_rd;
    w_id_entry.we      = id_rd_we;
    w_id_entry.is_load = id_is_load;
    w_id_entry.is_mem  = id_is_load | id_is_store;
  end

  fwd_unit u_fwd_a (
    .i_valid (id_valid),
    .i_used  (id_rs1_used),
    .i_rs    (id_rs1),
    .i_exe   (r_exe),
    .i_mem   (r_mem),
    .o_sel   (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_valid (id_valid),
    .i_used  (id_rs2_used),
    .i_rs    (id_rs2),
    .i_exe   (r_exe),
    .i_mem   (r_mem),
    .o_sel   (w_fwd_b)
  );

  // Shadow pipe and registered forwarding selects advance unless frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe   <= shadow_bubble();
      r_mem   <= shadow_bubble();
      r_wb    <= shadow_bubble();
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (!w_mem_wait) begin
      r_wb <= r_mem;
      if (w_branch) begin
        r_mem   <= shadow_bubble();
        r_exe   <= shadow_bubble();
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else if (w_lu_stall) begin
        r_mem   <= r_exe;
        r_exe   <= shadow_bubble();
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_mem   <= r_exe;
        r_exe   <= w_id_entry;
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
    end else begin
      r_exe   <= r_exe;
      r_mem   <= r_mem;
      r_wb    <= r_wb;
      r_fwd_a <= r_fwd_a;
      r_fwd_b <= r_fwd_b;
    end
  end

  // Hazard FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hazard FSM next state; memory wait overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (w_mem_wait) begin
      w_state_nxt = HZ_MEM_WAIT;
    end else begin
      case (r_state)
        HZ_RUN:      w_state_nxt = w_lu_stall ? HZ_LU_STALL : HZ_RUN;
        HZ_LU_STALL: w_state_nxt = HZ_RUN;
        HZ_MEM_WAIT: w_state_nxt = HZ_RUN;
        default:     w_state_nxt = HZ_RUN;
      endcase
    end
  end

  // Same-cycle pipeline control; forced quiet while reset is held.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_exe = 1'b0;
    freeze     = 1'b0;
    flush      = {BR_FLUSH{1'b0}};
    if (rst) begin
      flush = {BR_FLUSH{1'b0}};
    end else begin
      freeze     = w_mem_wait;
      stall_if   = w_mem_wait | w_lu_stall;
      stall_id   = w_mem_wait | w_lu_stall;
      bubble_exe = w_lu_stall;
      flush      = w_branch ? {BR_FLUSH{1'b1}} : {BR_FLUSH{1'b0}};
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters for stall/freeze cycles and branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if ((w_lu_stall || w_mem_wait) && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_branch && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_store;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       mem_br_taken, mem_ready;
  logic       stall_if, stall_id, bubble_exe, freeze;
  logic [2:0] flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .mem_br_taken(mem_br_taken), .mem_ready(mem_ready), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_exe(bubble_exe), .freeze(freeze), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit v; int rd; bit we; bit ld; bit mem; } ent_t;
  ent_t pipe[3];          // 0 = EXE, 1 = MEM, 2 = WB
  int   m_fa, m_fb;       // selects belonging to the instruction in EXE
  bit   m_held;           // ID did not advance on the last edge
  longint m_stall_cnt, m_flush_cnt;

  function automatic bit m_memwait();
    return pipe[1].v && pipe[1].mem && !mem_ready;
  endfunction

  function automatic bit m_branch();
    return mem_br_taken && !m_memwait();
  endfunction

  function automatic bit m_reads(int r);
    return id_valid && ((id_rs1_used && int'(id_rs1) == r) || (id_rs2_used && int'(id_rs2) == r));
  endfunction

  function automatic bit m_lu();
    return pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && m_reads(pipe[0].rd)
           && !m_branch() && !m_memwait();
  endfunction

  function automatic bit m_prod(ent_t e, int rs);
    return e.v && e.we && e.rd != 0 && e.rd == rs;
  endfunction

  function automatic int m_fwd(bit used, int rs);
    if (!id_valid || !used) return 0;
    if (m_prod(pipe[0], rs)) return 1;
    if (m_prod(pipe[1], rs)) return 2;
    return 0;
  endfunction

  // Model update on each clock edge, cleared asynchronously by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
      m_fa = 0; m_fb = 0; m_held = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      bit mw, br, lu;
      mw = m_memwait(); br = m_branch(); lu = m_lu();
      if ((mw || lu) && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (br && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
      m_held = mw || lu;
      if (mw) begin
        // frozen: nothing moves
      end else if (br) begin
        pipe[2] = pipe[1]; pipe[1] = '{0, 0, 0, 0, 0}; pipe[0] = '{0, 0, 0, 0, 0};
        m_fa = 0; m_fb = 0;
      end else if (lu) begin
        pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = '{0, 0, 0, 0, 0};
        m_fa = 0; m_fb = 0;
      end else begin
        m_fa = m_fwd(id_rs1_used, int'(id_rs1));
        m_fb = m_fwd(id_rs2_used, int'(id_rs2));
        pipe[2] = pipe[1]; pipe[1] = pipe[0];
        pipe[0] = '{id_valid, int'(id_rd), id_rd_we, id_is_load, id_is_load | id_is_store};
      end
    end
  end

  // Compare process: DUT against model on every negedge outside reset.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      bit mw, br, lu;
      mw = m_memwait(); br = m_branch(); lu = m_lu();
      check("m_freeze", freeze, mw);
      check("m_stall_if", stall_if, lu || mw);
      check("m_stall_id", stall_id, lu || mw);
      check("m_bubble", bubble_exe, lu);
      check("m_flush", flush, br ? 3'b111 : 3'b000);
      if (pipe[0].v) begin
        check("m_fwd_a", fwd_a_sel, m_fa);
        check("m_fwd_b", fwd_b_sel, m_fb);
      end
`ifdef HAZARD_PERF_EN
      check("m_perf_stall", perf_stall_cnt, m_stall_cnt[31:0]);
      check("m_perf_flush", perf_flush_cnt, m_flush_cnt[31:0]);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nop();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_load = 0; id_is_store = 0;
  endtask

  task automatic ins(input int rd, input bit we, input bit ld, input bit st,
                     input int r1, input bit u1, input int r2, input bit u2);
    id_valid = 1; id_rd = rd[4:0]; id_rd_we = we; id_is_load = ld; id_is_store = st;
    id_rs1 = r1[4:0]; id_rs1_used = u1; id_rs2 = r2[4:0]; id_rs2_used = u2;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic rand_id();
    int c, rd;
    c  = $urandom_range(0, 9);
    rd = $urandom_range(0, 3);
    if ($urandom_range(0, 99) < 15) nop();
    else if (c < 3) ins(rd, 1, 1, 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    else if (c == 3) ins(rd, 0, 0, 1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    else ins(rd, $urandom_range(0, 3) != 0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
  endtask

  initial begin
    int frz;
    nop(); mem_br_taken = 1; mem_ready = 1; rst = 1;
    // Reset state, including a branch request that must not flush.
    #12;
    check("rst_flush", flush, 3'b000);
    check("rst_stall", {stall_if, stall_id, bubble_exe, freeze}, 4'b0000);
    check("rst_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    mem_br_taken = 0;
    #10 rst = 0; chk_en = 1;
    nxt();

    // Dependent ALU op forwards from EXE/MEM.
    ins(5, 1, 0, 0, 1, 1, 2, 1); nxt();
    ins(8, 1, 0, 0, 5, 1, 0, 0); nxt();
    nop(); @(negedge clk); check("fwd_alu_01", fwd_a_sel, 2'b01); nxt();

    // One independent instruction in between forwards from MEM/WB.
    ins(5, 1, 0, 0, 1, 1, 2, 1); nxt();
    ins(7, 1, 0, 0, 1, 1, 2, 1); nxt();
    ins(8, 1, 0, 0, 5, 1, 0, 0); nxt();
    nop(); @(negedge clk); check("fwd_alu_10", fwd_a_sel, 2'b10); nxt();

    // Load-use: one bubble, then forward from MEM/WB.
    ins(6, 1, 1, 0, 1, 1, 2, 1); nxt();
    ins(9, 1, 0, 0, 0, 0, 6, 1);
    @(negedge clk);
    check("lu_stall_id", stall_id, 1'b1);
    check("lu_bubble", bubble_exe, 1'b1);
    nxt();
    @(negedge clk);
    check("lu_once_stall", stall_id, 1'b0);
    check("lu_once_bubble", bubble_exe, 1'b0);
    nxt();
    nop(); @(negedge clk); check("lu_fwd_b", fwd_b_sel, 2'b10); nxt();

    // Load to x0 never stalls or forwards.
    ins(0, 1, 1, 0, 1, 1, 2, 1); nxt();
    ins(10, 1, 0, 0, 0, 1, 0, 1);
    @(negedge clk); check("x0_no_stall", stall_id, 1'b0); nxt();
    nop(); @(negedge clk); check("x0_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000); nxt();

    // Store waits 3 cycles for memory: exactly 3 freeze cycles, selects held.
    ins(5, 1, 0, 0, 1, 1, 2, 1); nxt();
    ins(0, 0, 0, 1, 5, 1, 3, 1); nxt();
    ins(11, 1, 0, 0, 0, 0, 5, 1); nxt();
    nop(); mem_ready = 0; frz = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (freeze === 1'b1) frz++;
      check("frz_fwd_b", fwd_b_sel, 2'b10);
      check("frz_stall_if", stall_if, 1'b1);
      nxt();
    end
    mem_ready = 1;
    @(negedge clk);
    check("frz_count", frz, 3);
    check("frz_resume", freeze, 1'b0);
    nxt();

    // Taken branch coinciding with load-use: flush all, no stall.
    ins(6, 1, 1, 0, 1, 1, 2, 1); nxt();
    ins(12, 1, 0, 0, 6, 1, 0, 0); mem_br_taken = 1;
    @(negedge clk);
    check("br_flush", flush, 3'b111);
    check("br_no_stall", {stall_id, bubble_exe}, 2'b00);
    nxt();
    mem_br_taken = 0; nop();
    @(negedge clk);
    check("br_one_cycle", flush, 3'b000);
`ifdef HAZARD_PERF_EN
    check("br_perf_flush", perf_flush_cnt, 32'd1);
`endif
    nxt();

    // Reset asserted mid memory wait clears outputs asynchronously.
    ins(0, 0, 0, 1, 1, 1, 2, 1); nxt();
    nop(); nxt();
    mem_ready = 0;
    @(negedge clk); check("mw_freeze", freeze, 1'b1);
    #2 rst = 1;
    #1;
    check("arst_outs", {stall_if, stall_id, bubble_exe, freeze, flush}, 7'd0);
    check("arst_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    @(negedge clk); #2 rst = 0;
    nxt();
    @(negedge clk); check("arst_run", freeze, 1'b0);
    mem_ready = 1;
    nxt();

    // Randomized traffic checked by the compare process.
    for (int n = 0; n < 1500; n++) begin
      if (!m_held) rand_id();
      if (!(pipe[1].v && pipe[1].mem) && $urandom_range(0, 9) == 0) mem_br_taken = 1;
      else mem_br_taken = 0;
      mem_ready = ($urandom_range(0, 3) != 0);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
